// File: rtl/emulib_ckpt_pkg.sv
// Shared definitions for the checkpoint sequencer: host register map, bit positions,
// FSM encoding and the scan-chain DMA_CTRL command layout.
package emulib_ckpt_pkg;

    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_STATUS   = 6'h04;
    localparam logic [5:0] REG_INTERVAL = 6'h08;
    localparam logic [5:0] REG_CYCLE_LO = 6'h0C;
    localparam logic [5:0] REG_CYCLE_HI = 6'h10;
    localparam logic [5:0] REG_CKPT_CNT = 6'h14;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_SAVE    = 1;
    localparam int CTRL_RESTORE = 2;
    localparam int CTRL_AUTO_EN = 3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_STATE_LSB = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_START     = 3'd2,
        ST_POLL      = 3'd3,
        ST_DONE      = 3'd4
    } ckpt_state_e;

    localparam logic [5:0] SC_DMA_CTRL    = 6'h00;
    localparam int         SC_RUNNING_BIT = 0;
    localparam int         SC_DIR_BIT     = 1;

    // DMA_CTRL command word: start bit plus transfer direction (1 = restore / scan-in)
    function automatic logic [31:0] sc_dma_cmd(input logic dir);
        logic [31:0] cmd;
        cmd                 = '0;
        cmd[SC_RUNNING_BIT] = 1'b1;
        cmd[SC_DIR_BIT]     = dir;
        return cmd;
    endfunction

endpackage

// File: rtl/emulib_ckpt_timer.sv
// Emulated-cycle bookkeeping: 64-bit cycle counter, auto-checkpoint interval
// counter and the pending-request flag it raises.
module emulib_ckpt_timer #(
    parameter int INTERVAL_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clk_en,
    input  logic                      auto_en,
    input  logic [INTERVAL_WIDTH-1:0] interval,
    input  logic                      pend_clr,
    input  logic                      cyc_lo_we,
    input  logic                      cyc_hi_we,
    input  logic [31:0]               cyc_wdata,
    output logic [63:0]               cycle_cnt,
    output logic                      auto_pend
);

    logic [INTERVAL_WIDTH-1:0] ivl_cnt;
    logic [INTERVAL_WIDTH-1:0] ivl_nxt;
    logic                      ivl_tick;
    logic                      ivl_hit;

    assign ivl_nxt  = ivl_cnt + INTERVAL_WIDTH'(1);
    assign ivl_tick = clk_en && auto_en && (interval != '0);
    assign ivl_hit  = ivl_tick && (ivl_nxt == interval);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (cyc_lo_we) begin
            cycle_cnt[31:0] <= cyc_wdata;
        end else if (cyc_hi_we) begin
            cycle_cnt[63:32] <= cyc_wdata;
        end else if (clk_en) begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    // A clear coinciding with a hit wins: the save that clears it has just started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_cnt   <= '0;
            auto_pend <= 1'b0;
        end else begin
            if (ivl_hit) begin
                ivl_cnt <= '0;
            end else if (ivl_tick) begin
                ivl_cnt <= ivl_nxt;
            end
            if (pend_clr) begin
                auto_pend <= 1'b0;
            end else if (ivl_hit) begin
                auto_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/emulib_ckpt_sequencer.sv
// Checkpoint save/restore sequencer: host register file, freeze/DMA/poll FSM with
// timeout, and emulated-clock gating toward the model.
module emulib_ckpt_sequencer
    import emulib_ckpt_pkg::*;
#(
    parameter int INTERVAL_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        host_clk,
    input  logic        host_rst_n,
    input  logic        ctrl_wen,
    input  logic [5:0]  ctrl_waddr,
    input  logic [31:0] ctrl_wdata,
    input  logic        ctrl_ren,
    input  logic [5:0]  ctrl_raddr,
    output logic [31:0] ctrl_rdata,
    input  logic        emu_idle,
    output logic        emu_clk_en,
    output logic        sc_wen,
    output logic [5:0]  sc_waddr,
    output logic [31:0] sc_wdata,
    output logic        sc_ren,
    output logic [5:0]  sc_raddr,
    input  logic [31:0] sc_rdata,
    output logic        irq
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ckpt_state_e               state, state_d;
    logic                      dir, dir_d;
    logic                      run, run_d;
    logic                      auto_en;
    logic [INTERVAL_WIDTH-1:0] interval;
    logic                      done, err;
    logic [31:0]               ckpt_cnt;
    logic [TW-1:0]             tmo_cnt;
    logic                      tmo_expired;
    logic                      save_start, abort, done_evt;
    logic                      busy;
    logic [63:0]               cycle_cnt;
    logic                      auto_pend;
    logic                      unused_sc;

    logic wr_ctrl, wr_status, wr_interval, cyc_wr_ok;
    logic req_save, req_restore;

    assign wr_ctrl     = ctrl_wen && (ctrl_waddr == REG_CTRL);
    assign wr_status   = ctrl_wen && (ctrl_waddr == REG_STATUS);
    assign wr_interval = ctrl_wen && (ctrl_waddr == REG_INTERVAL);
    assign req_save    = wr_ctrl && ctrl_wdata[CTRL_SAVE];
    assign req_restore = wr_ctrl && ctrl_wdata[CTRL_RESTORE];
    assign busy        = (state != ST_IDLE);
    assign cyc_wr_ok   = !busy && !run;
    assign tmo_expired = (tmo_cnt == TMO_LAST);
    assign unused_sc   = ^sc_rdata[31:1];

    always_comb begin
        state_d    = state;
        dir_d      = dir;
        save_start = 1'b0;
        abort      = 1'b0;
        done_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_restore) begin
                    state_d = ST_WAIT_IDLE;
                    dir_d   = 1'b1;
                end else if (req_save || auto_pend) begin
                    state_d    = ST_WAIT_IDLE;
                    dir_d      = 1'b0;
                    save_start = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (emu_idle) begin
                    state_d = ST_START;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end
            end
            ST_START: state_d = ST_POLL;
            ST_POLL: begin
                // Completion seen on the last allowed poll still counts as success
                if (!sc_rdata[SC_RUNNING_BIT]) begin
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                done_evt = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        run_d = run;
        if (wr_ctrl) run_d = ctrl_wdata[CTRL_RUN];
        if (abort)   run_d = 1'b0;
    end

    always_ff @(posedge host_clk or negedge host_rst_n) begin
        if (!host_rst_n) begin
            state      <= ST_IDLE;
            dir        <= 1'b0;
            run        <= 1'b0;
            auto_en    <= 1'b0;
            interval   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            ckpt_cnt   <= '0;
            tmo_cnt    <= '0;
            emu_clk_en <= 1'b0;
        end else begin
            state      <= state_d;
            dir        <= dir_d;
            run        <= run_d;
            emu_clk_en <= run_d && (state_d == ST_IDLE);
            if (wr_ctrl)     auto_en  <= ctrl_wdata[CTRL_AUTO_EN];
            if (wr_interval) interval <= INTERVAL_WIDTH'(ctrl_wdata);
            // Hardware set beats a simultaneous W1C
            done <= done_evt | (done & ~(wr_status & ctrl_wdata[STAT_DONE]));
            err  <= abort    | (err  & ~(wr_status & ctrl_wdata[STAT_ERR]));
            if (done_evt) ckpt_cnt <= ckpt_cnt + 32'd1;
            if ((state_d != state) && ((state_d == ST_WAIT_IDLE) || (state_d == ST_POLL))) begin
                tmo_cnt <= '0;
            end else if ((state == ST_WAIT_IDLE) || (state == ST_POLL)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    emulib_ckpt_timer #(
        .INTERVAL_WIDTH (INTERVAL_WIDTH)
    ) u_timer (
        .clk       (host_clk),
        .rst_n     (host_rst_n),
        .clk_en    (emu_clk_en),
        .auto_en   (auto_en),
        .interval  (interval),
        .pend_clr  (save_start || (wr_ctrl && !ctrl_wdata[CTRL_AUTO_EN])),
        .cyc_lo_we (ctrl_wen && (ctrl_waddr == REG_CYCLE_LO) && cyc_wr_ok),
        .cyc_hi_we (ctrl_wen && (ctrl_waddr == REG_CYCLE_HI) && cyc_wr_ok),
        .cyc_wdata (ctrl_wdata),
        .cycle_cnt (cycle_cnt),
        .auto_pend (auto_pend)
    );

    assign sc_wen   = (state == ST_START);
    assign sc_ren   = (state == ST_POLL);
    assign sc_waddr = SC_DMA_CTRL;
    assign sc_raddr = SC_DMA_CTRL;
    assign sc_wdata = sc_dma_cmd(dir);
    assign irq      = done | err;

    always_comb begin
        ctrl_rdata = '0;
        if (ctrl_ren) begin
            case (ctrl_raddr)
                REG_CTRL: begin
                    ctrl_rdata[CTRL_RUN]     = run;
                    ctrl_rdata[CTRL_AUTO_EN] = auto_en;
                end
                REG_STATUS: begin
                    ctrl_rdata[STAT_BUSY] = busy;
                    ctrl_rdata[STAT_DONE] = done;
                    ctrl_rdata[STAT_ERR]  = err;
                    ctrl_rdata[STAT_STATE_LSB +: 3] = state;
                end
                REG_INTERVAL: ctrl_rdata = 32'(interval);
                REG_CYCLE_LO: ctrl_rdata = cycle_cnt[31:0];
                REG_CYCLE_HI: ctrl_rdata = cycle_cnt[63:32];
                REG_CKPT_CNT: ctrl_rdata = ckpt_cnt;
                default:      ctrl_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_emulib_ckpt_sequencer.sv
// Directed bench for the checkpoint sequencer: free run, save, restore, auto
// checkpoints, poll timeout and asynchronous reset in the middle of a sequence.
module tb_emulib_ckpt_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ctrl_wen;
    logic [5:0]  ctrl_waddr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_ren;
    logic [5:0]  ctrl_raddr;
    logic [31:0] ctrl_rdata;
    logic        emu_idle;
    logic        emu_clk_en;
    logic        sc_wen;
    logic [5:0]  sc_waddr;
    logic [31:0] sc_wdata;
    logic        sc_ren;
    logic [5:0]  sc_raddr;
    logic [31:0] sc_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_INTERVAL = 6'h08;
    localparam logic [5:0] A_LO = 6'h0C, A_HI = 6'h10, A_CKPT = 6'h14;

    emulib_ckpt_sequencer #(
        .INTERVAL_WIDTH (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .host_clk   (clk),
        .host_rst_n (rst_n),
        .ctrl_wen   (ctrl_wen),
        .ctrl_waddr (ctrl_waddr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_ren   (ctrl_ren),
        .ctrl_raddr (ctrl_raddr),
        .ctrl_rdata (ctrl_rdata),
        .emu_idle   (emu_idle),
        .emu_clk_en (emu_clk_en),
        .sc_wen     (sc_wen),
        .sc_waddr   (sc_waddr),
        .sc_wdata   (sc_wdata),
        .sc_ren     (sc_ren),
        .sc_raddr   (sc_raddr),
        .sc_rdata   (sc_rdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        ctrl_wen   = 1'b1;
        ctrl_waddr = a;
        ctrl_wdata = d;
        @(posedge clk);
        #1;
        ctrl_wen   = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        ctrl_ren   = 1'b1;
        ctrl_raddr = a;
        #1;
        d          = ctrl_rdata;
        ctrl_ren   = 1'b0;
    endtask

    // Ticks until STATUS.BUSY rises, bounded; returns number of edges taken
    task automatic wait_busy(output int n);
        logic [31:0] s;
        n = 0;
        rd(A_STATUS, s);
        while (!s[0] && n < 200) begin
            tick(1);
            n++;
            rd(A_STATUS, s);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] lo_a;
        logic        act;
        int          n;

        rst_n      = 1'b0;
        ctrl_wen   = 1'b0;
        ctrl_waddr = '0;
        ctrl_wdata = '0;
        ctrl_ren   = 1'b0;
        ctrl_raddr = '0;
        emu_idle   = 1'b0;
        sc_rdata   = '0;
        tick(3);

        // Reset state
        check("rst_clk_en", 64'(emu_clk_en), 64'd0);
        check("rst_sc_wen", 64'(sc_wen), 64'd0);
        check("rst_sc_ren", 64'(sc_ren), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        rst_n = 1'b1;
        tick(1);
        rd(A_CTRL, r);   check("rst_ctrl", 64'(r), 64'd0);
        rd(A_STATUS, r); check("rst_status", 64'(r), 64'd0);
        rd(A_CKPT, r);   check("rst_ckpt", 64'(r), 64'd0);

        // Free run: 100 enabled cycles, no scan-chain traffic
        wr(A_CTRL, 32'h1);
        check("run_clk_en", 64'(emu_clk_en), 64'd1);
        act = 1'b0;
        for (int i = 0; i < 100; i++) begin
            act = act | sc_wen | sc_ren;
            tick(1);
        end
        check("run_no_sc", 64'(act), 64'd0);
        rd(A_LO, r); check("run_cycle_lo", 64'(r), 64'd100);
        wr(A_HI, 32'h5);
        rd(A_HI, r); check("run_hi_write_dropped", 64'(r), 64'd0);
        rd(A_LO, r); check("run_cycle_lo_101", 64'(r), 64'd101);

        // Save, scan chain reports RUNNING for 5 polls
        emu_idle = 1'b1;
        sc_rdata = 32'h1;
        wr(A_CTRL, 32'h3);
        check("save_freeze", 64'(emu_clk_en), 64'd0);
        rd(A_STATUS, r); check("save_wait_status", 64'(r), 64'h11);
        tick(1);
        check("save_sc_wen", 64'(sc_wen), 64'd1);
        check("save_sc_wdata", 64'(sc_wdata), 64'h1);
        check("save_sc_waddr", 64'(sc_waddr), 64'd0);
        tick(1);
        check("save_wen_pulse", 64'(sc_wen), 64'd0);
        check("save_sc_ren", 64'(sc_ren), 64'd1);
        rd(A_STATUS, r); check("save_poll_status", 64'(r), 64'h31);
        tick(4);
        rd(A_STATUS, r); check("save_poll5_status", 64'(r), 64'h31);
        sc_rdata = 32'h0;
        tick(1);
        rd(A_STATUS, r); check("save_done_state", 64'(r), 64'h41);
        tick(1);
        rd(A_STATUS, r); check("save_status_done", 64'(r), 64'h2);
        check("save_irq", 64'(irq), 64'd1);
        rd(A_CKPT, r); check("save_ckpt", 64'(r), 64'd1);
        check("save_resume", 64'(emu_clk_en), 64'd1);
        wr(A_STATUS, 32'h2);
        check("done_w1c_irq", 64'(irq), 64'd0);

        // Restore with model busy for 10 cycles
        emu_idle = 1'b0;
        sc_rdata = 32'h1;
        wr(A_CTRL, 32'h5);
        act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            act = act | emu_clk_en | sc_wen;
            tick(1);
        end
        check("rest_frozen_wait", 64'(act), 64'd0);
        emu_idle = 1'b1;
        tick(1);
        check("rest_sc_wen", 64'(sc_wen), 64'd1);
        check("rest_sc_wdata", 64'(sc_wdata), 64'h3);
        sc_rdata = 32'h0;
        tick(3);
        rd(A_CKPT, r); check("rest_ckpt", 64'(r), 64'd2);
        wr(A_STATUS, 32'h2);

        // Auto checkpoints every 50 enabled cycles
        wr(A_INTERVAL, 32'd50);
        wr(A_CTRL, 32'h9);
        wait_busy(n);
        check("auto_first_edges", 64'(n), 64'd51);
        rd(A_LO, lo_a);
        tick(1);
        check("auto_sc_wen", 64'(sc_wen), 64'd1);
        check("auto_dir_save", 64'(sc_wdata), 64'h1);
        tick(3);
        rd(A_LO, r); check("auto_cycles_frozen", 64'(r), 64'(lo_a));
        rd(A_CKPT, r); check("auto_ckpt1", 64'(r), 64'd3);
        wait_busy(n);
        check("auto_repeat_edges", 64'(n), 64'd50);
        tick(4);
        rd(A_CKPT, r); check("auto_ckpt2", 64'(r), 64'd4);
        wr(A_CTRL, 32'h1);
        wr(A_STATUS, 32'h2);

        // Poll timeout with DMA stuck running; SAVE while busy is dropped
        sc_rdata = 32'h1;
        wr(A_CTRL, 32'h3);
        tick(2);
        rd(A_STATUS, r); check("tmo_poll1", 64'(r), 64'h31);
        wr(A_CTRL, 32'h3);
        tick(14);
        rd(A_STATUS, r); check("tmo_poll16", 64'(r), 64'h31);
        tick(1);
        rd(A_STATUS, r); check("tmo_err_status", 64'(r), 64'h4);
        check("tmo_irq", 64'(irq), 64'd1);
        rd(A_CTRL, r); check("tmo_run_cleared", 64'(r), 64'd0);
        rd(A_CKPT, r); check("tmo_ckpt", 64'(r), 64'd4);
        check("tmo_clk_en", 64'(emu_clk_en), 64'd0);
        tick(1);
        rd(A_STATUS, r); check("tmo_no_queue", 64'(r), 64'h4);

        // Asynchronous reset during POLL
        wr(A_CTRL, 32'h3);
        tick(2);
        check("arst_pre_ren", 64'(sc_ren), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_sc_ren", 64'(sc_ren), 64'd0);
        check("arst_clk_en", 64'(emu_clk_en), 64'd0);
        check("arst_irq", 64'(irq), 64'd0);
        rd(A_STATUS, r); check("arst_status", 64'(r), 64'd0);
        rd(A_CKPT, r);   check("arst_ckpt", 64'(r), 64'd0);
        rst_n = 1'b1;
        tick(1);
        wr(A_HI, 32'h7);
        rd(A_HI, r); check("idle_hi_write", 64'(r), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
